// File: rtl/aes_core_static_128_hs.sv
// Static-key AES-128 encrypt/decrypt core with valid/ready handshakes, a held
// output register and SBOX_COLS columns of S-box substitution per cycle.
module aes_core_static_128_hs #(
  parameter logic [127:0] KEY         = 128'h000102030405060708090a0b0c0d0e0f,
  parameter int unsigned  SBOX_COLS   = 1,
  parameter bit           SILENT_SBOX = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_i,
  input  logic         dec_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_o,
  output logic         busy_o
);

  localparam int unsigned NSB = 4 / SBOX_COLS;

  if (SBOX_COLS != 1 && SBOX_COLS != 2 && SBOX_COLS != 4) begin : g_bad_cols
    $error("SBOX_COLS must be 1, 2 or 4");
  end

  typedef enum logic [2:0] {IDLE, CLR, INIT, SBOX, RK, DONE} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xtime(a);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq = a;
    logic [7:0] r  = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] key, input int unsigned idx);
    logic [31:0] w0 = key[127:96], w1 = key[95:64], w2 = key[63:32], w3 = key[31:0];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int unsigned r = 1; r <= idx; r++) begin
      t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rc = xtime(rc);
    end
    return {w0, w1, w2, w3};
  endfunction

  // Byte i of the state lives at bits [127-8*i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((inv ? (c + 4 - r) : (c + r)) % 4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
    logic [127:0] o = '0;
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    coef = inv ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++) begin
        acc = '0;
        for (int unsigned k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[(k + 4 - r) % 4], s[127-8*(4*c+k) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  logic [127:0] rk [11];
  for (genvar g = 0; g < 11; g++) begin : g_rk
    assign rk[g] = key_expand(KEY, g);
  end

  state_e       state_q, state_d;
  logic [127:0] text_q, text_d, stext_q, stext_d, din_q, din_d, dout_q, dout_d;
  logic [1:0]   col_q, col_d;
  logic [3:0]   round_q, round_d;
  logic         dec_q, dec_d;

  logic [127:0] sb_in, sb_out, sx, rk_mix, rk_next;
  logic         last_round;

  // Decrypt folds the previous round's InvMixColumns into this round's S-box input.
  always_comb begin
    sb_in = '0;
    if (dec_q) sb_in = shift_rows((round_q == 4'd9) ? text_q : mix_columns(text_q, 1'b1), 1'b1);
    else       sb_in = text_q;
    sb_out = '0;
    for (int unsigned i = 0; i < 16; i++)
      sb_out[127-8*i -: 8] = dec_q ? inv_sbox(sb_in[127-8*i -: 8]) : sbox(sb_in[127-8*i -: 8]);
  end

  always_comb begin
    sx = (SILENT_SBOX && state_q == SBOX) ? '0 : stext_q;
    if (dec_q)                 rk_mix = sx;
    else if (round_q == 4'd10) rk_mix = shift_rows(sx, 1'b0);
    else                       rk_mix = mix_columns(shift_rows(sx, 1'b0), 1'b0);
    rk_next    = rk_mix ^ rk[round_q];
    last_round = dec_q ? (round_q == 4'd0) : (round_q == 4'd10);
  end

  always_comb begin
    state_d = state_q;
    text_d  = text_q;
    stext_d = stext_q;
    din_d   = din_q;
    dout_d  = dout_q;
    col_d   = col_q;
    round_d = round_q;
    dec_d   = dec_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        din_d   = data_i;
        dec_d   = dec_i;
        state_d = CLR;
      end
      CLR: begin
        round_d = dec_q ? 4'd9 : 4'd1;
        text_d  = '0;
        stext_d = '0;
        col_d   = '0;
        state_d = INIT;
      end
      INIT: begin
        text_d  = din_q ^ rk[dec_q ? 4'd10 : 4'd0];
        state_d = SBOX;
      end
      SBOX: begin
        for (int unsigned j = 0; j < 4; j++)
          if (col_q == 2'(j / SBOX_COLS)) stext_d[127-32*j -: 32] = sb_out[127-32*j -: 32];
        if (col_q == 2'(NSB - 1)) begin
          col_d   = '0;
          state_d = RK;
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      RK: begin
        text_d = rk_next;
        if (last_round) begin
          dout_d  = rk_next;
          state_d = DONE;
        end else begin
          round_d = dec_q ? round_q - 4'd1 : round_q + 4'd1;
          state_d = SBOX;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      text_q  <= '0;
      stext_q <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      col_q   <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      text_q  <= text_d;
      stext_q <= stext_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      col_q   <= col_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy_o    = (state_q != IDLE) && (state_q != DONE);
  assign data_o    = dout_q;

endmodule

// File: tb/tb_aes_core_static_128_hs.sv
// Directed and round-trip bench for aes_core_static_128_hs with three S-box widths.
module tb_aes_core_static_128_hs;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ALT = 128'hdeadbeef0123456789abcdeffedcba98;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         dec       [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         busy      [3];
  logic [127:0] din       [3];
  logic [127:0] dout      [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // index 0: 4 columns, masked; index 1: 1 column, unmasked; index 2: 2 columns, masked
  aes_core_static_128_hs #(.KEY(128'h000102030405060708090a0b0c0d0e0f), .SBOX_COLS(4), .SILENT_SBOX(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .data_i(din[0]),
    .dec_i(dec[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .data_o(dout[0]), .busy_o(busy[0]));
  aes_core_static_128_hs #(.KEY(128'h000102030405060708090a0b0c0d0e0f), .SBOX_COLS(1), .SILENT_SBOX(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .data_i(din[1]),
    .dec_i(dec[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .data_o(dout[1]), .busy_o(busy[1]));
  aes_core_static_128_hs #(.KEY(128'h000102030405060708090a0b0c0d0e0f), .SBOX_COLS(2), .SILENT_SBOX(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .data_i(din[2]),
    .dec_i(dec[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .data_o(dout[2]), .busy_o(busy[2]));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input int idx, input logic [127:0] d, input logic dm);
    int guard = 0;
    while (!in_ready[idx] && guard < 100) begin
      tick();
      guard++;
    end
    check("wait_in_ready", 128'(in_ready[idx]), 128'd1);
    in_valid[idx] = 1'b1;
    din[idx]      = d;
    dec[idx]      = dm;
    tick();
    in_valid[idx] = 1'b0;
  endtask

  task automatic wait_result(input int idx, output int lat);
    lat = 0;
    while (!out_valid[idx] && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_block(input int idx, output logic [127:0] res, output int lat);
    wait_result(idx, lat);
    res            = dout[idx];
    out_ready[idx] = 1'b1;
    tick();
    out_ready[idx] = 1'b0;
  endtask

  task automatic run_block(input int idx, input logic [127:0] d, input logic dm,
                           output logic [127:0] res, output int lat);
    start_block(idx, d, dm);
    finish_block(idx, res, lat);
  endtask

  initial begin
    logic [127:0] res, p, c;
    int lat;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      dec[i]       = 1'b0;
      din[i]       = '0;
    end
    #12;
    check("rst_in_ready", 128'(in_ready[0]), 128'd1);
    check("rst_out_valid", 128'(out_valid[0]), 128'd0);
    check("rst_busy", 128'(busy[0]), 128'd0);
    check("rst_data_o", dout[0], 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // known-answer encrypt/decrypt with latency on every width
    run_block(0, PT, 1'b0, res, lat);
    check("enc4_data", res, CT);
    check("enc4_lat", 128'(lat), 128'd22);
    run_block(1, CT, 1'b1, res, lat);
    check("dec1_data", res, PT);
    check("dec1_lat", 128'(lat), 128'd52);
    run_block(2, CT, 1'b1, res, lat);
    check("dec2_data", res, PT);
    check("dec2_lat", 128'(lat), 128'd32);
    run_block(1, PT, 1'b0, res, lat);
    check("enc1_data", res, CT);
    run_block(2, PT, 1'b0, res, lat);
    check("enc2_data", res, CT);
    check("enc2_lat", 128'(lat), 128'd32);
    run_block(0, CT, 1'b1, res, lat);
    check("dec4_data", res, PT);
    check("dec4_lat", 128'(lat), 128'd22);
    check("hold_between", dout[0], PT);

    // back-pressure: result held while out_ready stays low
    start_block(0, PT, 1'b0);
    wait_result(0, lat);
    check("bp_lat", 128'(lat), 128'd22);
    repeat (10) tick();
    check("bp_out_valid", 128'(out_valid[0]), 128'd1);
    check("bp_data_o", dout[0], CT);
    check("bp_in_ready", 128'(in_ready[0]), 128'd0);
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    check("bp_in_ready_after", 128'(in_ready[0]), 128'd1);
    check("bp_out_valid_after", 128'(out_valid[0]), 128'd0);
    run_block(0, CT, 1'b1, res, lat);
    check("bp_second_block", res, PT);

    // in_valid while busy must be ignored
    start_block(0, PT, 1'b0);
    repeat (5) tick();
    check("ign_busy", 128'(busy[0]), 128'd1);
    in_valid[0] = 1'b1;
    din[0]      = ALT;
    dec[0]      = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    finish_block(0, res, lat);
    check("ign_result", res, CT);

    // asynchronous reset mid-block
    start_block(0, ALT, 1'b0);
    repeat (10) tick();
    check("arst_busy_before", 128'(busy[0]), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(out_valid[0]), 128'd0);
    check("arst_busy", 128'(busy[0]), 128'd0);
    check("arst_data_o", dout[0], 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_in_ready", 128'(in_ready[0]), 128'd1);
    run_block(0, PT, 1'b0, res, lat);
    check("arst_enc", res, CT);

    // random round trips, masked (4 cols) and unmasked (1 col)
    for (int i = 0; i < 100; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      run_block(0, p, 1'b0, c, lat);
      run_block(0, c, 1'b1, res, lat);
      check("rt4", res, p);
    end
    for (int i = 0; i < 100; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      run_block(1, p, 1'b0, c, lat);
      run_block(1, c, 1'b1, res, lat);
      check("rt1", res, p);
      check("rt1_lat", 128'(lat), 128'd52);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
